// File: rtl/sfifo_pkg.sv
// sfifo_pkg: constants and helpers shared by the sfifo top and its RAM.
//   SFIFO_NORMAL / SFIFO_SHOWAHEAD : values for the SHOWAHEAD parameter
//   ST_IDLE / ST_FETCH / ST_VALID  : show-ahead prefetch state encoding
//   usedw_width()                  : width of the occupancy count
package sfifo_pkg;

    localparam int SFIFO_NORMAL    = 0;
    localparam int SFIFO_SHOWAHEAD = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    // Occupancy runs 0..DEPTH inclusive, so one bit wider than an address.
    function automatic int usedw_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sfifo_mem.sv
// sfifo_mem: simple dual-port, single-clock RAM with a registered read port.
// Ports:
//   clock      in   rising-edge clock
//   wren       in   write enable
//   wraddress  in   write address
//   data       in   write word
//   rden       in   read enable; q updates only on an enabled read
//   rdaddress  in   read address
//   q          out  registered read word
// Small memories map to distributed RAM, larger ones to block RAM.
// On a same-address read and write in one cycle the read returns the old
// word; the FIFO relies on this when it is full and reads/writes together.
module sfifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (ADDR_WIDTH <= 5) begin : g_dist
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clock) begin
                if (wren) mem[wraddress] <= data;
                if (rden) q <= mem[rdaddress];
            end
        end else begin : g_block
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clock) begin
                if (wren) mem[wraddress] <= data;
                if (rden) q <= mem[rdaddress];
            end
        end
    endgenerate

endmodule

// File: rtl/sfifo.sv
// sfifo: single-clock synchronous FIFO with occupancy count, almost-full /
// almost-empty thresholds and an optional show-ahead (FWFT) read mode.
// Ports:
//   clock         in   rising-edge clock
//   sclr          in   synchronous active-high clear
//   data          in   write word
//   wrreq         in   write request
//   rdreq         in   read / pop request
//   q             out  read word
//   empty         out  no readable word
//   full          out  usedw == DEPTH
//   almost_full   out  usedw >= ALMOST_FULL_LVL
//   almost_empty  out  usedw <  ALMOST_EMPTY_LVL
//   usedw         out  words held, 0..DEPTH
//   overflow      out  sticky, rejected write   (only with SFIFO_ERRFLAG_EN)
//   underflow     out  sticky, read while empty (only with SFIFO_ERRFLAG_EN)
//
// Show-ahead prefetch states:
//   state    | meaning
//   ST_IDLE  | no word presented, no RAM read in flight
//   ST_FETCH | RAM read issued last edge; its word is on the RAM output
//   ST_VALID | presented word is stable on the RAM output
// The RAM's registered read port doubles as the one-word output register;
// valid_q marks whether it holds a presentable word.
module sfifo
    import sfifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 10,
    parameter int SHOWAHEAD        = SFIFO_NORMAL,
    parameter int ALMOST_FULL_LVL  = (2 ** ADDR_WIDTH) - 4,
    parameter int ALMOST_EMPTY_LVL = 4
) (
    input  logic                                  clock,
    input  logic                                  sclr,
    input  logic [DATA_WIDTH-1:0]                 data,
    input  logic                                  wrreq,
    input  logic                                  rdreq,
    output logic [DATA_WIDTH-1:0]                 q,
    output logic                                  empty,
    output logic                                  full,
    output logic                                  almost_full,
    output logic                                  almost_empty,
    output logic [usedw_width(ADDR_WIDTH)-1:0]    usedw
`ifdef SFIFO_ERRFLAG_EN
    ,
    output logic                                  overflow,
    output logic                                  underflow
`endif
);

    localparam int UW = usedw_width(ADDR_WIDTH);
    localparam bit FWFT = (SHOWAHEAD == SFIFO_SHOWAHEAD);
    localparam logic [UW-1:0] DEPTH_C = UW'(2 ** ADDR_WIDTH);
    localparam logic [UW-1:0] AF_C    = UW'(ALMOST_FULL_LVL);
    localparam logic [UW-1:0] AE_C    = UW'(ALMOST_EMPTY_LVL);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]         usedw_q, usedw_d, ram_cnt_q, ram_cnt_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  valid_q, valid_d, q_clr_q, q_clr_d;
    logic [1:0]            state_q, state_d;
    logic                  wr_acc, rd_acc, ram_rden;
    logic [DATA_WIDTH-1:0] ram_q;

    always_comb begin
        rd_acc = rdreq && !empty_q;
        wr_acc = wrreq && (!full_q || rd_acc);

        wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;

        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + UW'(1);
            2'b01:   usedw_d = usedw_q - UW'(1);
            default: usedw_d = usedw_q;
        endcase

        state_d  = state_q;
        valid_d  = valid_q;
        ram_rden = 1'b0;
        if (FWFT) begin
            // A pop and the RAM read for the next word share one edge, so
            // back-to-back pops see a fresh word every cycle.
            case (state_q)
                ST_IDLE: begin
                    if (ram_cnt_q != '0) begin
                        ram_rden = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
                ST_FETCH, ST_VALID: begin
                    if (rd_acc) begin
                        if (ram_cnt_q != '0) begin
                            ram_rden = 1'b1;
                            state_d  = ST_FETCH;
                        end else begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_VALID;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end else begin
            ram_rden = rd_acc;
        end

        // Words still inside the RAM, not yet moved to the output register.
        case ({wr_acc, ram_rden})
            2'b10:   ram_cnt_d = ram_cnt_q + UW'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - UW'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase

        rd_ptr_d = ram_rden ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

        // The RAM output is not reset, so q is forced to zero after a clear
        // until the first read refills the output register.
        q_clr_d = q_clr_q && !ram_rden;

        empty_d = FWFT ? !valid_d : (usedw_d == '0);
        full_d  = (usedw_d == DEPTH_C);
        af_d    = (usedw_d >= AF_C);
        ae_d    = (usedw_d < AE_C);
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usedw_q   <= '0;
            ram_cnt_q <= '0;
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            q_clr_q   <= 1'b1;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            usedw_q   <= usedw_d;
            ram_cnt_q <= ram_cnt_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            q_clr_q   <= q_clr_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
        end
    end

    sfifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clock     (clock),
        .wren      (wr_acc),
        .wraddress (wr_ptr_q),
        .data      (data),
        .rden      (ram_rden),
        .rdaddress (rd_ptr_q),
        .q         (ram_q)
    );

    assign q            = q_clr_q ? '0 : ram_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign usedw        = usedw_q;

`ifdef SFIFO_ERRFLAG_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q || (wrreq && !wr_acc);
        underflow_d = underflow_q || (rdreq && empty_q);
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sfifo.sv
// tb_sfifo: directed bench for sfifo in normal and show-ahead modes, checked
// against a queue-based behavioural model on every cycle plus literal pins.
module tb_sfifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sclr_n, wrreq_n, rdreq_n, sclr_f, wrreq_f, rdreq_f;
    logic [15:0] data_n, data_f, q_n, q_f;
    logic        empty_n, full_n, af_n, ae_n, empty_f, full_f, af_f, ae_f;
    logic [4:0]  usedw_n, usedw_f;
`ifdef SFIFO_ERRFLAG_EN
    logic        ovf_n, udf_n, ovf_f, udf_f;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    sfifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .SHOWAHEAD(0),
            .ALMOST_FULL_LVL(12), .ALMOST_EMPTY_LVL(4)) u_n (
        .clock(clk), .sclr(sclr_n), .data(data_n), .wrreq(wrreq_n), .rdreq(rdreq_n),
        .q(q_n), .empty(empty_n), .full(full_n), .almost_full(af_n),
        .almost_empty(ae_n),
`ifdef SFIFO_ERRFLAG_EN
        .overflow(ovf_n), .underflow(udf_n),
`endif
        .usedw(usedw_n)
    );

    sfifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .SHOWAHEAD(1),
            .ALMOST_FULL_LVL(12), .ALMOST_EMPTY_LVL(4)) u_f (
        .clock(clk), .sclr(sclr_f), .data(data_f), .wrreq(wrreq_f), .rdreq(rdreq_f),
        .q(q_f), .empty(empty_f), .full(full_f), .almost_full(af_f),
        .almost_empty(ae_f),
`ifdef SFIFO_ERRFLAG_EN
        .overflow(ovf_f), .underflow(udf_f),
`endif
        .usedw(usedw_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Normal-mode model: a plain queue plus the last popped word.
    logic [15:0] mq[$];
    logic [15:0] mq_q;
    bit          m_ovf_n, m_udf_n;

    always @(posedge clk) begin : m_norm
        bit rd_ok, wr_ok;
        if (sclr_n) begin
            mq.delete();
            mq_q = 16'h0;
            m_ovf_n = 1'b0;
            m_udf_n = 1'b0;
        end else begin
            rd_ok = rdreq_n && (mq.size() != 0);
            wr_ok = wrreq_n && ((mq.size() < 16) || rd_ok);
            if (rdreq_n && mq.size() == 0) m_udf_n = 1'b1;
            if (wrreq_n && !wr_ok) m_ovf_n = 1'b1;
            if (rd_ok) mq_q = mq.pop_front();
            if (wr_ok) mq.push_back(data_n);
        end
    end

    // Show-ahead model: each word carries the edge it was written on. A word
    // written into an idle FIFO is presented two edges later; after a pop the
    // next word is presented at once if it was written on an earlier edge.
    typedef struct {
        logic [15:0] d;
        int          t;
    } ent_t;
    ent_t fq[$];
    bit   f_vis, m_ovf_f, m_udf_f;
    int   ecnt = 0;

    always @(posedge clk) begin : m_fwft
        bit rd_ok, wr_ok;
        ecnt++;
        if (sclr_f) begin
            fq.delete();
            f_vis = 1'b0;
            m_ovf_f = 1'b0;
            m_udf_f = 1'b0;
        end else begin
            rd_ok = rdreq_f && f_vis;
            wr_ok = wrreq_f && ((fq.size() < 16) || rd_ok);
            if (rdreq_f && !f_vis) m_udf_f = 1'b1;
            if (wrreq_f && !wr_ok) m_ovf_f = 1'b1;
            if (rd_ok) begin
                void'(fq.pop_front());
                f_vis = (fq.size() != 0) && (fq[0].t < ecnt);
            end
            if (wr_ok) fq.push_back('{data_f, ecnt});
            if (!f_vis && fq.size() != 0 && ecnt >= fq[0].t + 2) f_vis = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("n_usedw", usedw_n, mq.size());
            chk("n_empty", empty_n, mq.size() == 0);
            chk("n_full",  full_n,  mq.size() == 16);
            chk("n_af",    af_n,    mq.size() >= 12);
            chk("n_ae",    ae_n,    mq.size() < 4);
            chk("n_q",     q_n,     mq_q);
            chk("f_usedw", usedw_f, fq.size());
            chk("f_empty", empty_f, !f_vis);
            chk("f_full",  full_f,  fq.size() == 16);
            chk("f_af",    af_f,    fq.size() >= 12);
            chk("f_ae",    ae_f,    fq.size() < 4);
            if (f_vis) chk("f_q", q_f, fq[0].d);
`ifdef SFIFO_ERRFLAG_EN
            chk("n_ovf", ovf_n, m_ovf_n);
            chk("n_udf", udf_n, m_udf_n);
            chk("f_ovf", ovf_f, m_ovf_f);
            chk("f_udf", udf_f, m_udf_f);
`endif
        end
    end

    task automatic cyc_n(input logic wr, input logic [15:0] d, input logic rd);
        wrreq_n = wr;
        data_n  = d;
        rdreq_n = rd;
        @(posedge clk);
        #1;
        wrreq_n = 1'b0;
        rdreq_n = 1'b0;
    endtask

    task automatic cyc_f(input logic wr, input logic [15:0] d, input logic rd);
        wrreq_f = wr;
        data_f  = d;
        rdreq_f = rd;
        @(posedge clk);
        #1;
        wrreq_f = 1'b0;
        rdreq_f = 1'b0;
    endtask

    initial begin
        sclr_n = 1'b1; wrreq_n = 1'b0; rdreq_n = 1'b0; data_n = 16'h0;
        sclr_f = 1'b1; wrreq_f = 1'b0; rdreq_f = 1'b0; data_f = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_usedw", usedw_n, 0);
        chk("rst_empty", empty_n, 1);
        chk("rst_full",  full_n,  0);
        chk("rst_af",    af_n,    0);
        chk("rst_ae",    ae_n,    1);
        chk("rst_q",     q_n,     0);
        chk("rst_f_empty", empty_f, 1);
        chk("rst_f_q",     q_f,     0);
        sclr_n = 1'b0;
        sclr_f = 1'b0;

        // Normal mode: fill, threshold edges, overflow attempt.
        for (int i = 1; i <= 16; i++) begin
            cyc_n(1'b1, 16'(i), 1'b0);
            if (i == 3)  chk("ae_at3",  ae_n, 1);
            if (i == 4)  chk("ae_at4",  ae_n, 0);
            if (i == 11) chk("af_at11", af_n, 0);
            if (i == 12) chk("af_at12", af_n, 1);
        end
        chk("fill_full",  full_n,  1);
        chk("fill_usedw", usedw_n, 16);
        cyc_n(1'b1, 16'hDEAD, 1'b0);
        chk("ovf_usedw", usedw_n, 16);
`ifdef SFIFO_ERRFLAG_EN
        chk("ovf_flag", ovf_n, 1);
`endif
        for (int i = 1; i <= 16; i++) begin
            cyc_n(1'b0, 16'h0, 1'b1);
            chk("drain_q", q_n, i);
        end
        chk("drain_empty", empty_n, 1);
        chk("drain_usedw", usedw_n, 0);
        cyc_n(1'b0, 16'h0, 1'b1);
        chk("udf_q", q_n, 16'h0010);
`ifdef SFIFO_ERRFLAG_EN
        chk("udf_flag", udf_n, 1);
`endif

        // Full with read+write together across pointer wrap.
        for (int i = 0; i < 16; i++) cyc_n(1'b1, 16'h0020 + 16'(i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc_n(1'b1, 16'h0040 + 16'(i), 1'b1);
            chk("rw_q",     q_n,     16'h0020 + 16'(i));
            chk("rw_usedw", usedw_n, 16);
            chk("rw_full",  full_n,  1);
        end
        for (int i = 0; i < 4; i++) cyc_n(1'b0, 16'h0, 1'b1);
        chk("af_at12_rd", af_n, 1);
        cyc_n(1'b0, 16'h0, 1'b1);
        chk("af_fall_usedw", usedw_n, 11);
        chk("af_fall",       af_n,    0);
        chk("af_fall_q",     q_n,     16'h002C);
        for (int i = 0; i < 11; i++) cyc_n(1'b0, 16'h0, 1'b1);
        chk("wrap_last_q", q_n,     16'h0047);
        chk("wrap_empty",  empty_n, 1);
        cyc_n(1'b1, 16'h0055, 1'b1);
        chk("wr_rd_empty_usedw", usedw_n, 1);
        chk("wr_rd_empty_q",     q_n,     16'h0047);
        cyc_n(1'b0, 16'h0, 1'b1);
        chk("wr_rd_empty_rd", q_n, 16'h0055);

        // Clear mid-stream with a write in the same cycle.
        for (int i = 0; i < 9; i++) cyc_n(1'b1, 16'h0060 + 16'(i), 1'b0);
        chk("pre_clr_usedw", usedw_n, 9);
        sclr_n = 1'b1; wrreq_n = 1'b1; data_n = 16'hBEEF;
        @(posedge clk);
        #1;
        sclr_n = 1'b0; wrreq_n = 1'b0;
        chk("clr_usedw", usedw_n, 0);
        chk("clr_empty", empty_n, 1);
        chk("clr_q",     q_n,     0);
        cyc_n(1'b0, 16'h0, 1'b0);
        chk("clr_discard", usedw_n, 0);

        // Show-ahead: two-edge latency into an empty FIFO.
        cyc_f(1'b1, 16'h00AA, 1'b0);
        chk("fw_n0_empty", empty_f, 1);
        cyc_f(1'b0, 16'h0, 1'b0);
        chk("fw_n1_empty", empty_f, 1);
        cyc_f(1'b0, 16'h0, 1'b0);
        chk("fw_n2_empty", empty_f, 0);
        chk("fw_n2_q",     q_f,     16'h00AA);
        cyc_f(1'b0, 16'h0, 1'b1);
        chk("fw_pop_empty", empty_f, 1);

        // Back-to-back pops over five words, no bubble.
        for (int i = 0; i < 5; i++) cyc_f(1'b1, 16'h0011 + 16'(i), 1'b0);
        cyc_f(1'b0, 16'h0, 1'b0);
        cyc_f(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("fw_burst_q",     q_f,     16'h0011 + 16'(i));
            chk("fw_burst_empty", empty_f, 0);
            cyc_f(1'b0, 16'h0, 1'b1);
        end
        chk("fw_burst_done", empty_f, 1);

        // Show-ahead full with simultaneous read+write.
        for (int i = 0; i < 18; i++) cyc_f(1'b1, 16'h0100 + 16'(i), 1'b0);
        chk("fw_full_usedw", usedw_f, 16);
        chk("fw_full",       full_f,  1);
        for (int i = 0; i < 4; i++) begin
            cyc_f(1'b1, 16'h0200 + 16'(i), 1'b1);
            chk("fw_rw_q",     q_f,     16'h0101 + 16'(i));
            chk("fw_rw_usedw", usedw_f, 16);
        end
        for (int i = 0; i < 18; i++) cyc_f(1'b0, 16'h0, 1'b1);
        chk("fw_drained", empty_f, 1);

        // Mixed traffic on both instances, model-checked every cycle.
        for (int k = 0; k < 400; k++) begin
            int thr;
            thr = ((k / 50) % 2 == 0) ? 3 : 1;
            wrreq_n = ($urandom_range(0, 3) < thr);
            rdreq_n = ($urandom_range(0, 3) >= thr);
            data_n  = 16'($urandom);
            wrreq_f = ($urandom_range(0, 3) < thr);
            rdreq_f = ($urandom_range(0, 3) >= 4 - thr) || ($urandom_range(0, 1) == 1);
            data_f  = 16'($urandom);
            sclr_n  = (k == 250);
            sclr_f  = (k == 260);
            @(posedge clk);
            #1;
        end
        sclr_n = 1'b0; sclr_f = 1'b0;
        wrreq_n = 1'b0; rdreq_n = 1'b0; wrreq_f = 1'b0; rdreq_f = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
